// File: rtl/hazard_ctrl_if.sv
// Control bundle between the RV32I decode/execute buffers and the hazard controller.
// The pipeline side is the master (drives instructions and status); the controller is the slave.
interface hazard_ctrl_if;
  logic [31:0] ir_id;
  logic [31:0] ir_ex;
  logic        br_taken;
  logic        dmem_busy;
  logic        pc_en;
  logic        ir_en;
  logic        bubble;
  logic        flush;
  logic        fwd_sela;
  logic        fwd_selb;

  modport master (
    output ir_id, ir_ex, br_taken, dmem_busy,
    input  pc_en, ir_en, bubble, flush, fwd_sela, fwd_selb
  );

  modport slave (
    input  ir_id, ir_ex, br_taken, dmem_busy,
    output pc_en, ir_en, bubble, flush, fwd_sela, fwd_selb
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory-stall freeze
// with timeout watchdog, EX-result forwarding selects and saturating perf counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_STALL = 2'd1,
    ST_ERR       = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [WAIT_W-1:0]  wait_nxt_s;

  logic [4:0] rs1_id_s;
  logic [4:0] rs2_id_s;
  logic [4:0] rd_ex_s;
  logic       ex_is_load_s;
  logic       load_use_s;

  logic run_pc_en_s;
  logic run_ir_en_s;
  logic run_bubble_s;
  logic run_flush_s;

  logic pc_en_s;
  logic ir_en_s;
  logic bubble_s;
  logic flush_s;
  logic fwd_ok_s;

  // Register-field decode; fields an opcode does not use collapse to x0.
  always_comb begin
    rs1_id_s     = 5'd0;
    rs2_id_s     = 5'd0;
    rd_ex_s      = 5'd0;
    ex_is_load_s = 1'b0;
    case (hz.ir_id[6:0])
      OP_R, OP_STORE, OP_BRANCH: begin
        rs1_id_s = hz.ir_id[19:15];
        rs2_id_s = hz.ir_id[24:20];
      end
      OP_I_ALU, OP_LOAD, OP_JALR: begin
        rs1_id_s = hz.ir_id[19:15];
      end
      default: begin
        rs1_id_s = 5'd0;
      end
    endcase
    case (hz.ir_ex[6:0])
      OP_LOAD: begin
        rd_ex_s      = hz.ir_ex[11:7];
        ex_is_load_s = 1'b1;
      end
      OP_R, OP_I_ALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
        rd_ex_s = hz.ir_ex[11:7];
      end
      default: begin
        rd_ex_s = 5'd0;
      end
    endcase
  end

  assign load_use_s = ex_is_load_s && (rd_ex_s != 5'd0) &&
                      ((rd_ex_s == rs1_id_s) || (rd_ex_s == rs2_id_s));

  // Unstalled pipeline behaviour: branch beats load-use, load-use beats normal flow.
  always_comb begin
    run_pc_en_s  = 1'b1;
    run_ir_en_s  = 1'b1;
    run_bubble_s = 1'b0;
    run_flush_s  = 1'b0;
    if (hz.br_taken) begin
      run_flush_s  = 1'b1;
      run_bubble_s = 1'b1;
    end else if (load_use_s) begin
      run_pc_en_s  = 1'b0;
      run_ir_en_s  = 1'b0;
      run_bubble_s = 1'b1;
    end else begin
      run_flush_s  = 1'b0;
    end
  end

  // Next-state and control outputs; reset and ERR both kill both buffers.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_cnt_r;
    pc_en_s     = 1'b0;
    ir_en_s     = 1'b0;
    bubble_s    = 1'b1;
    flush_s     = 1'b1;
    if (rst) begin
      state_nxt_s = ST_RUN;
      wait_nxt_s  = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hz.dmem_busy) begin
            bubble_s    = 1'b0;
            flush_s     = 1'b0;
            state_nxt_s = ST_MEM_STALL;
            wait_nxt_s  = WAIT_W'(1);
          end else begin
            pc_en_s  = run_pc_en_s;
            ir_en_s  = run_ir_en_s;
            bubble_s = run_bubble_s;
            flush_s  = run_flush_s;
          end
        end
        ST_MEM_STALL: begin
          if (hz.dmem_busy) begin
            bubble_s = 1'b0;
            flush_s  = 1'b0;
            if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
              state_nxt_s = ST_ERR;
            end else begin
              wait_nxt_s = wait_cnt_r + WAIT_W'(1);
            end
          end else begin
            pc_en_s     = run_pc_en_s;
            ir_en_s     = run_ir_en_s;
            bubble_s    = run_bubble_s;
            flush_s     = run_flush_s;
            state_nxt_s = ST_RUN;
            wait_nxt_s  = '0;
          end
        end
        ST_ERR: begin
          state_nxt_s = ST_ERR;
        end
        default: begin
          state_nxt_s = ST_ERR;
        end
      endcase
    end
  end

  // Forwarding is only meaningful while EX is actually advancing.
  assign fwd_ok_s    = !rst && (state_r == ST_RUN) && !hz.dmem_busy &&
                       (rd_ex_s != 5'd0) && !ex_is_load_s;
  assign hz.fwd_sela = fwd_ok_s && (rd_ex_s == rs1_id_s);
  assign hz.fwd_selb = fwd_ok_s && (rd_ex_s == rs2_id_s);
  assign hz.pc_en    = pc_en_s;
  assign hz.ir_en    = ir_en_s;
  assign hz.bubble   = bubble_s;
  assign hz.flush    = flush_s;

  // State, watchdog, sticky error and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= '0;
      mem_err    <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      mem_err    <= mem_err || (state_nxt_s == ST_ERR);
      if ((state_r != ST_ERR) && !pc_en_s && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if ((state_r != ST_ERR) && flush_s && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule
